// File: rtl/iob_ram_sp_be_arb_pkg.sv
// rtl/iob_ram_sp_be_arb_pkg.sv - shared types and constants for the RAM arbiter
//
// Holds the controller state encoding, the requester index constants used to
// address the two-bit request/grant vectors, and the strobe-width helper.
package iob_ram_sp_be_arb_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  // One write-enable bit per data byte.
  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/iob_rr_arb2.sv
// rtl/iob_rr_arb2.sv - two-way round-robin grant with last-grant register
//
// Ports:
//   clk_i, arst_n_i  clock, asynchronous active-low reset
//   en_i             arbitration enable; no grant is issued while low
//   req_i[1:0]       requests, indexed by REQ_A / REQ_B
//   gnt_o[1:0]       one-hot (or zero) grant, combinational from req_i
module iob_rr_arb2
  import iob_ram_sp_be_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       arst_n_i,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic last_grant;

  // A tie goes to whichever requester was not served last.
  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (req_i[REQ_A] && req_i[REQ_B]) begin
        if (last_grant == REQ_B) gnt_o[REQ_A] = 1'b1;
        else                     gnt_o[REQ_B] = 1'b1;
      end else begin
        gnt_o = req_i;
      end
    end
  end

  // Reset to B so that A wins the very first tie.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      last_grant <= REQ_B;
    end else if (|gnt_o) begin
      last_grant <= gnt_o[REQ_B] ? REQ_B : REQ_A;
    end
  end

endmodule

// File: rtl/iob_ram_sp_be_arb.sv
// rtl/iob_ram_sp_be_arb.sv - two-requester arbiter/sequencer for a byte-enable SP RAM
//
// Ports:
//   clk_i, arst_n_i              clock, asynchronous active-low reset
//   a_* / b_*                    requester ports: valid/addr/wdata/wstrb in,
//                                ready (accept), rvalid/rdata (read response) out;
//                                wstrb all-zero means read
//   ram_en_o, ram_we_o,
//   ram_addr_o, ram_d_o, ram_d_i RAM macro interface, read data one cycle late
//   init_done_o                  high in RUN (after the optional zero-fill)
module iob_ram_sp_be_arb
  import iob_ram_sp_be_arb_pkg::*;
#(
  parameter  int ADDR_W   = 10,
  parameter  int DATA_W   = 32,
  parameter  int CLEAR_EN = 1,
  localparam int STRB_W   = strb_w(DATA_W)
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              a_valid_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  input  logic [STRB_W-1:0] a_wstrb_i,
  output logic              a_ready_o,
  output logic              a_rvalid_o,
  output logic [DATA_W-1:0] a_rdata_o,
  input  logic              b_valid_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_wdata_i,
  input  logic [STRB_W-1:0] b_wstrb_i,
  output logic              b_ready_o,
  output logic              b_rvalid_o,
  output logic [DATA_W-1:0] b_rdata_o,
  output logic              ram_en_o,
  output logic [STRB_W-1:0] ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_d_o,
  input  logic [DATA_W-1:0] ram_d_i,
  output logic              init_done_o
);

  state_e            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic              rd_pend_a, rd_pend_b;
  logic [1:0]        gnt;
  logic              arb_en;

  // Reset is folded into the enable so that no grant (and hence no RAM
  // access) is presented while reset is held, even in RUN with CLEAR_EN=0.
  assign arb_en = arst_n_i && (state == ST_RUN);

  iob_rr_arb2 u_arb (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .en_i     (arb_en),
    .req_i    ({b_valid_i, a_valid_i}),
    .gnt_o    (gnt)
  );

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state     <= (CLEAR_EN != 0) ? ST_CLEAR : ST_RUN;
      clr_cnt   <= '0;
      rd_pend_a <= 1'b0;
      rd_pend_b <= 1'b0;
    end else begin
      state     <= state_nxt;
      if (state == ST_CLEAR) clr_cnt <= clr_cnt + ADDR_W'(1);
      rd_pend_a <= gnt[REQ_A] && (a_wstrb_i == '0);
      rd_pend_b <= gnt[REQ_B] && (b_wstrb_i == '0);
    end
  end

  always_comb begin
    state_nxt  = state;
    ram_en_o   = 1'b0;
    ram_we_o   = '0;
    ram_addr_o = '0;
    ram_d_o    = '0;
    if (state == ST_CLEAR && clr_cnt == '1) state_nxt = ST_RUN;
    if (arst_n_i) begin
      if (state == ST_CLEAR) begin
        ram_en_o   = 1'b1;
        ram_we_o   = '1;
        ram_addr_o = clr_cnt;
      end else if (gnt[REQ_A]) begin
        ram_en_o   = 1'b1;
        ram_we_o   = a_wstrb_i;
        ram_addr_o = a_addr_i;
        ram_d_o    = a_wdata_i;
      end else if (gnt[REQ_B]) begin
        ram_en_o   = 1'b1;
        ram_we_o   = b_wstrb_i;
        ram_addr_o = b_addr_i;
        ram_d_o    = b_wdata_i;
      end
    end
  end

  assign a_ready_o   = gnt[REQ_A];
  assign b_ready_o   = gnt[REQ_B];
  assign a_rvalid_o  = rd_pend_a;
  assign b_rvalid_o  = rd_pend_b;
  // Read data is a pass-through of the RAM output, zeroed when not valid.
  assign a_rdata_o   = rd_pend_a ? ram_d_i : '0;
  assign b_rdata_o   = rd_pend_b ? ram_d_i : '0;
  assign init_done_o = (state == ST_RUN);

endmodule

// File: tb/tb_iob_ram_sp_be_arb.sv
// tb/tb_iob_ram_sp_be_arb.sv - scoreboard bench for iob_ram_sp_be_arb
module tb_iob_ram_sp_be_arb;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  // Instance with CLEAR_EN=1
  logic          a_valid, a_ready, a_rvalid, b_valid, b_ready, b_rvalid;
  logic [AW-1:0] a_addr, b_addr, ram_addr;
  logic [DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata, ram_d, ram_q;
  logic [SW-1:0] a_wstrb, b_wstrb, ram_we;
  logic          ram_en, init_done;

  // Instance with CLEAR_EN=0
  logic          c_a_valid, c_a_ready, c_a_rvalid, c_b_ready, c_b_rvalid;
  logic [AW-1:0] c_a_addr, c_ram_addr;
  logic [DW-1:0] c_a_rdata, c_b_rdata, c_ram_d, c_ram_q;
  logic [SW-1:0] c_ram_we;
  logic          c_ram_en, c_init_done;

  iob_ram_sp_be_arb #(.ADDR_W(AW), .DATA_W(DW), .CLEAR_EN(1)) dut (
    .clk_i(clk), .arst_n_i(arst_n),
    .a_valid_i(a_valid), .a_addr_i(a_addr), .a_wdata_i(a_wdata), .a_wstrb_i(a_wstrb),
    .a_ready_o(a_ready), .a_rvalid_o(a_rvalid), .a_rdata_o(a_rdata),
    .b_valid_i(b_valid), .b_addr_i(b_addr), .b_wdata_i(b_wdata), .b_wstrb_i(b_wstrb),
    .b_ready_o(b_ready), .b_rvalid_o(b_rvalid), .b_rdata_o(b_rdata),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_d_o(ram_d),
    .ram_d_i(ram_q), .init_done_o(init_done)
  );

  iob_ram_sp_be_arb #(.ADDR_W(AW), .DATA_W(DW), .CLEAR_EN(0)) dut_nc (
    .clk_i(clk), .arst_n_i(arst_n),
    .a_valid_i(c_a_valid), .a_addr_i(c_a_addr), .a_wdata_i('0), .a_wstrb_i('0),
    .a_ready_o(c_a_ready), .a_rvalid_o(c_a_rvalid), .a_rdata_o(c_a_rdata),
    .b_valid_i(1'b0), .b_addr_i('0), .b_wdata_i('0), .b_wstrb_i('0),
    .b_ready_o(c_b_ready), .b_rvalid_o(c_b_rvalid), .b_rdata_o(c_b_rdata),
    .ram_en_o(c_ram_en), .ram_we_o(c_ram_we), .ram_addr_o(c_ram_addr), .ram_d_o(c_ram_d),
    .ram_d_i(c_ram_q), .init_done_o(c_init_done)
  );

  // RAM model: prefilled with all ones during reset, read-first, byte writes.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (!arst_n) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= '1;
    end else if (ram_en) begin
      for (int b = 0; b < SW; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_d[8*b +: 8];
      ram_q <= mem[ram_addr];
    end
  end

  always @(posedge clk) if (c_ram_en) c_ram_q <= 32'hC0DE0000 | 32'(c_ram_addr);

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic          port;
    logic [DW-1:0] data;
  } rsp_t;
  rsp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_rsp(input logic port, input logic [DW-1:0] data);
    rsp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL rsp_unexpected: got port %0d data %h expected no response at %0t",
               port, data, $time);
    end else begin
      e = exp_q.pop_front();
      chk("rsp_port", 32'(port), 32'(e.port));
      chk("rsp_data", data, e.data);
    end
  endtask

  // Monitor: every response the DUT presents is matched against the queue.
  always @(negedge clk) begin
    if (a_rvalid) check_rsp(1'b0, a_rdata);
    if (b_rvalid) check_rsp(1'b1, b_rdata);
  end

  task automatic push(input logic port, input logic [DW-1:0] data);
    rsp_t e;
    e.port = port;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic set_a(input logic v, input logic [AW-1:0] ad,
                       input logic [DW-1:0] wd, input logic [SW-1:0] ws);
    a_valid = v; a_addr = ad; a_wdata = wd; a_wstrb = ws;
  endtask

  task automatic set_b(input logic v, input logic [AW-1:0] ad,
                       input logic [DW-1:0] wd, input logic [SW-1:0] ws);
    b_valid = v; b_addr = ad; b_wdata = wd; b_wstrb = ws;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    arst_n = 1'b0;
    set_a(1'b1, 4'd5, '0, '0);
    set_b(1'b0, '0, '0, '0);
    c_a_valid = 1'b1;
    c_a_addr  = 4'd7;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ram_en",   32'(ram_en), 0);
    chk("rst_ram_we",   32'(ram_we), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_d",    ram_d, 0);
    chk("rst_a_ready",  32'(a_ready), 0);
    chk("rst_b_ready",  32'(b_ready), 0);
    chk("rst_a_rvalid", 32'(a_rvalid), 0);
    chk("rst_a_rdata",  a_rdata, 0);
    chk("rst_init",     32'(init_done), 0);
    chk("rst_nc_init",  32'(c_init_done), 1);
    chk("rst_nc_ready", 32'(c_a_ready), 0);
    step;
    arst_n = 1'b1;

    // Zero-fill: 16 cycles with A held off, while the CLEAR_EN=0 copy runs.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("clr_a_ready", 32'(a_ready), 0);
      chk("clr_ram_en",  32'(ram_en), 1);
      chk("clr_ram_we",  32'(ram_we), 32'hF);
      chk("clr_addr",    32'(ram_addr), i);
      chk("clr_d",       ram_d, 0);
      chk("clr_init",    32'(init_done), 0);
      if (i == 0) begin
        chk("nc_init",  32'(c_init_done), 1);
        chk("nc_ready", 32'(c_a_ready), 1);
      end
      if (i == 1) begin
        chk("nc_rvalid", 32'(c_a_rvalid), 1);
        chk("nc_rdata",  c_a_rdata, 32'hC0DE0007);
      end
      step;
      c_a_valid = 1'b0;
    end
    @(negedge clk);
    chk("run_init",    32'(init_done), 1);
    chk("run_a_ready", 32'(a_ready), 1);
    push(1'b0, 32'h00000000);
    step;

    // Full write, partial overwrite from B, read back via A.
    set_a(1'b1, 4'd3, 32'hDEADBEEF, 4'hF);
    @(negedge clk); chk("wr_a_ready", 32'(a_ready), 1); chk("wr_a_we", 32'(ram_we), 32'hF);
    step;
    set_a(1'b0, '0, '0, '0);
    set_b(1'b1, 4'd3, 32'h000000AA, 4'h1);
    @(negedge clk); chk("wr_b_ready", 32'(b_ready), 1); chk("wr_b_we", 32'(ram_we), 32'h1);
    step;
    set_b(1'b0, '0, '0, '0);
    set_a(1'b1, 4'd3, '0, '0);
    @(negedge clk); chk("rd3_a_ready", 32'(a_ready), 1);
    push(1'b0, 32'hDEADBEAA);
    step;

    // Seed addresses 1 and 2 (A then B, leaving last_grant = B).
    set_a(1'b1, 4'd1, 32'h11111111, 4'hF);
    @(negedge clk); chk("wr1_a_ready", 32'(a_ready), 1);
    step;
    set_a(1'b0, '0, '0, '0);
    set_b(1'b1, 4'd2, 32'h22222222, 4'hF);
    @(negedge clk); chk("wr2_b_ready", 32'(b_ready), 1);
    step;

    // B alone three times, then both: A must take the first tie.
    set_b(1'b1, 4'd2, '0, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bonly_b_ready", 32'(b_ready), 1);
      chk("bonly_a_ready", 32'(a_ready), 0);
      push(1'b1, 32'h22222222);
      step;
    end
    set_a(1'b1, 4'd1, '0, '0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k % 2 == 0) begin
        chk("alt_a_ready", 32'(a_ready), 1);
        chk("alt_b_ready", 32'(b_ready), 0);
        chk("alt_addr",    32'(ram_addr), 1);
        push(1'b0, 32'h11111111);
      end else begin
        chk("alt_a_ready", 32'(a_ready), 0);
        chk("alt_b_ready", 32'(b_ready), 1);
        chk("alt_addr",    32'(ram_addr), 2);
        push(1'b1, 32'h22222222);
      end
      step;
    end
    set_a(1'b0, '0, '0, '0);
    set_b(1'b0, '0, '0, '0);
    step;
    step;
    chk("sb_drained", exp_q.size(), 0);

    // Reset right after a granted read: the response must vanish.
    set_a(1'b1, 4'd5, '0, '0);
    @(negedge clk); chk("mid_a_ready", 32'(a_ready), 1);
    step;
    arst_n = 1'b0;
    set_a(1'b0, '0, '0, '0);
    @(negedge clk);
    chk("mid_rvalid", 32'(a_rvalid), 0);
    chk("mid_ram_en", 32'(ram_en), 0);
    chk("mid_ram_we", 32'(ram_we), 0);
    chk("mid_init",   32'(init_done), 0);
    step;
    step;
    arst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reclr_en",   32'(ram_en), 1);
      chk("reclr_addr", 32'(ram_addr), i);
      chk("reclr_we",   32'(ram_we), 32'hF);
      step;
    end
    repeat (13) step;
    @(negedge clk);
    chk("reclr_init", 32'(init_done), 1);
    step;
    chk("sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
